// File: rtl/perf_sample_buffer_pkg.sv
// perf_sample_buffer_pkg: shared FSM states, register offsets and counter address helper
package perf_sample_buffer_pkg;
  typedef enum logic [1:0] {IDLE, READ, LAST} state_t;
  localparam logic [31:0] REG_CONTROL  = 32'd0;
  localparam logic [31:0] REG_INTERVAL = 32'd4;
  localparam logic [31:0] REG_STATUS   = 32'd8;
  localparam logic [31:0] REG_DATA     = 32'd12;
  localparam logic [31:0] COUNTER_OFS  = 32'd16;
  function automatic logic [31:0] counter_addr(input logic [31:0] base, input logic [31:0] k);
    return base + COUNTER_OFS + (k << 2);
  endfunction
endpackage

// File: rtl/io_bus_interface.sv
// io_bus_interface: simple single-cycle register bus with registered read data
interface io_bus_interface;
  logic        read_en;
  logic        write_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  modport master(output read_en, write_en, address, write_data, input read_data);
  modport slave(input read_en, write_en, address, write_data, output read_data);
endinterface

// File: rtl/perf_sample_buffer_fifo.sv
// sample_fifo: synchronous FIFO with wrapping pointers, occupancy count and status flags
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int DI = DEPTH;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == DI[AW:0];
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/perf_sample_buffer.sv
// perf_sample_buffer: interval-timed snapshot of all perf counters into a host-drained FIFO
module perf_sample_buffer
  import perf_sample_buffer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'd0,
  parameter logic [31:0] COUNTER_BASE = 32'd0,
  parameter int          NUM_COUNTERS = 4,
  parameter int          FIFO_DEPTH   = 16
) (
  input logic             clk,
  input logic             reset,
  io_bus_interface.master counter_bus,
  io_bus_interface.slave  host_bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = NUM_COUNTERS > 1 ? $clog2(NUM_COUNTERS) : 1;
  localparam int DI = FIFO_DEPTH;
  localparam int NI = NUM_COUNTERS;
  localparam int LI = NUM_COUNTERS - 1;
  localparam logic [AW:0]   DEPTH_C  = DI[AW:0];
  localparam logic [AW:0]   NUM_C    = NI[AW:0];
  localparam logic [IW-1:0] LAST_IDX = LI[IW-1:0];
  state_t        state;
  logic [IW-1:0] idx;
  logic          enable, overflow, cap_valid, rd_en;
  logic          ctrl_wr, int_wr, data_rd, expiry, start, full, empty;
  logic [31:0]   interval, timer, rd_addr, host_rdata, rd_val, head;
  logic [AW:0]   count, free;
  assign ctrl_wr = host_bus.write_en && host_bus.address == BASE_ADDRESS + REG_CONTROL;
  assign int_wr  = host_bus.write_en && host_bus.address == BASE_ADDRESS + REG_INTERVAL;
  assign data_rd = host_bus.read_en && host_bus.address == BASE_ADDRESS + REG_DATA;
  assign free    = DEPTH_C - count;
  assign expiry  = enable && interval != '0 && timer == '0 && state == IDLE;
  // space for the whole sample is reserved up front so a sample is never split
  assign start   = expiry && !full && free >= NUM_C;
  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cap_valid),
    .push_data (counter_bus.read_data),
    .pop       (data_rd),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );
  always_comb
    rd_val = host_bus.address == BASE_ADDRESS + REG_STATUS ? {overflow, 15'd0, 16'(count)} :
             (host_bus.address == BASE_ADDRESS + REG_DATA && !empty) ? head : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable     <= 1'b0;
      interval   <= '0;
      timer      <= '0;
      overflow   <= 1'b0;
      host_rdata <= '0;
    end else begin
      if (ctrl_wr) enable <= host_bus.write_data[0];
      if (int_wr) interval <= host_bus.write_data;
      if ((ctrl_wr && host_bus.write_data[0]) || expiry)
        timer <= interval == '0 ? '0 : interval - 32'd1;
      else if (enable && interval != '0 && timer != '0)
        timer <= timer - 32'd1;
      if (expiry && !start) overflow <= 1'b1;
      else if (ctrl_wr && host_bus.write_data[1]) overflow <= 1'b0;
      host_rdata <= host_bus.read_en ? rd_val : '0;
    end
  end
  // read_en is high exactly while in READ; the returned word is pushed one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      cap_valid <= 1'b0;
    end else begin
      cap_valid <= rd_en;
      case (state)
        IDLE: if (start) begin
          state   <= READ;
          idx     <= '0;
          rd_en   <= 1'b1;
          rd_addr <= counter_addr(COUNTER_BASE, 32'd0);
        end
        READ: if (idx == LAST_IDX) begin
          state   <= LAST;
          rd_en   <= 1'b0;
          rd_addr <= '0;
        end else begin
          idx     <= idx + 1'b1;
          rd_addr <= counter_addr(COUNTER_BASE, 32'(idx) + 32'd1);
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign counter_bus.read_en    = rd_en;
  assign counter_bus.address    = rd_addr;
  assign counter_bus.write_en   = 1'b0;
  assign counter_bus.write_data = '0;
  assign host_bus.read_data     = host_rdata;
endmodule
